wb_commit_stage: RTL

- Parametrised N-lane MEM→WB pipeline register with valid/ready handshake; successor to the fixed dual-lane WB latch.
- Distinguishes hold (backpressure) from flush (clear), which the previous block merged into one clear.
- Applies in-order commit rules:
  - an excepting lane squashes all younger lanes;
  - writes to register r0 are suppressed;
  - retired instructions are counted.
- Outputs feed the regfile write port, the CSR unit, the exception controller and the forwarding network.

---
 rtl/wb_commit_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_stage.sv
// MEM->WB group register for LANES lanes: squashes lanes younger than the oldest exception,
// suppresses r0/excepting writes, counts retirements. One-cycle latency; in_ready = !held || out_ready.
module wb_commit_stage #(
    parameter int LANES      = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int CSR_ADDR_W = 14,
    parameter int EXC_W      = 7,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [LANES-1:0]              in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_W-1:0]       in_pc,
    input  logic [LANES-1:0]              in_rf_we,
    input  logic [LANES*ADDR_W-1:0]       in_rf_addr,
    input  logic [LANES*DATA_W-1:0]       in_rf_data,
    input  logic [LANES-1:0]              in_csr_we,
    input  logic [LANES*CSR_ADDR_W-1:0]   in_csr_addr,
    input  logic [LANES*DATA_W-1:0]       in_csr_data,
    input  logic [LANES-1:0]              in_exc,
    input  logic [LANES*EXC_W-1:0]        in_exc_code,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_valid,
    output logic [LANES*DATA_W-1:0]       out_pc,
    output logic [LANES-1:0]              out_rf_we,
    output logic [LANES*ADDR_W-1:0]       out_rf_addr,
    output logic [LANES*DATA_W-1:0]       out_rf_data,
    output logic [LANES-1:0]              out_csr_we,
    output logic [LANES*CSR_ADDR_W-1:0]   out_csr_addr,
    output logic [LANES*DATA_W-1:0]       out_csr_data,
    output logic [LANES-1:0]              out_exc,
    output logic [LANES*EXC_W-1:0]        out_exc_code,
    output logic                          exc_fire,
    output logic [CNT_W-1:0]              retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [LANES-1:0]            valid_q, valid_d;
    logic [LANES-1:0]            rf_we_q, rf_we_d;
    logic [LANES-1:0]            csr_we_q, csr_we_d;
    logic [LANES-1:0]            exc_q, exc_d;
    logic [LANES*DATA_W-1:0]     pc_q, pc_d;
    logic [LANES*ADDR_W-1:0]     rf_addr_q, rf_addr_d;
    logic [LANES*DATA_W-1:0]     rf_data_q, rf_data_d;
    logic [LANES*CSR_ADDR_W-1:0] csr_addr_q, csr_addr_d;
    logic [LANES*DATA_W-1:0]     csr_data_q, csr_data_d;
    logic [LANES*EXC_W-1:0]      exc_code_q, exc_code_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        fire_q, fire_d;

    logic             held, load, drain;
    logic [LANES-1:0] sq_valid, sq_exc, sq_rf_we, sq_csr_we;
    logic             exc_seen;
    logic [CNT_W-1:0] retire_inc;

    assign held     = |valid_q;
    assign in_ready = !held || out_ready;
    assign load     = in_ready && (|in_valid) && !flush;
    assign drain    = held && out_ready;

    // Write enables are qualified at load; valid/exc only ever clear while held, so this stays exact.
    always_comb begin
        sq_valid  = '0;
        sq_exc    = '0;
        sq_rf_we  = '0;
        sq_csr_we = '0;
        exc_seen  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!exc_seen) begin
                sq_valid[i]  = in_valid[i];
                sq_exc[i]    = in_valid[i] && in_exc[i];
                sq_rf_we[i]  = in_valid[i] && !in_exc[i] && in_rf_we[i]
                               && (in_rf_addr[i*ADDR_W +: ADDR_W] != '0);
                sq_csr_we[i] = in_valid[i] && !in_exc[i] && in_csr_we[i];
                if (in_valid[i] && in_exc[i]) begin
                    exc_seen = 1'b1;
                end
            end
        end
    end

    always_comb begin
        retire_inc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (valid_q[i] && !exc_q[i]) begin
                retire_inc = retire_inc + CNT_ONE;
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        rf_we_d    = rf_we_q;
        csr_we_d   = csr_we_q;
        exc_d      = exc_q;
        pc_d       = pc_q;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        csr_addr_d = csr_addr_q;
        csr_data_d = csr_data_q;
        exc_code_d = exc_code_q;
        cnt_d      = cnt_q;
        fire_d     = 1'b0;
        if (flush) begin
            valid_d  = '0;
            rf_we_d  = '0;
            csr_we_d = '0;
            exc_d    = '0;
        end else begin
            if (drain) begin
                cnt_d  = cnt_q + retire_inc;
                fire_d = |exc_q;
            end
            if (load) begin
                valid_d    = sq_valid;
                rf_we_d    = sq_rf_we;
                csr_we_d   = sq_csr_we;
                exc_d      = sq_exc;
                pc_d       = in_pc;
                rf_addr_d  = in_rf_addr;
                rf_data_d  = in_rf_data;
                csr_addr_d = in_csr_addr;
                csr_data_d = in_csr_data;
                exc_code_d = in_exc_code;
            end else if (drain) begin
                valid_d  = '0;
                rf_we_d  = '0;
                csr_we_d = '0;
                exc_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            rf_we_q    <= '0;
            csr_we_q   <= '0;
            exc_q      <= '0;
            pc_q       <= '0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            csr_addr_q <= '0;
            csr_data_q <= '0;
            exc_code_q <= '0;
            cnt_q      <= '0;
            fire_q     <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rf_we_q    <= rf_we_d;
            csr_we_q   <= csr_we_d;
            exc_q      <= exc_d;
            pc_q       <= pc_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            csr_addr_q <= csr_addr_d;
            csr_data_q <= csr_data_d;
            exc_code_q <= exc_code_d;
            cnt_q      <= cnt_d;
            fire_q     <= fire_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_rf_we    = rf_we_q;
    assign out_csr_we   = csr_we_q;
    assign out_exc      = exc_q;
    assign out_pc       = pc_q;
    assign out_rf_addr  = rf_addr_q;
    assign out_rf_data  = rf_data_q;
    assign out_csr_addr = csr_addr_q;
    assign out_csr_data = csr_data_q;
    assign out_exc_code = exc_code_q;
    assign exc_fire     = fire_q;
    assign retire_cnt   = cnt_q;

endmodule
